// File: rtl/oam_dma_ctrl_pkg.sv
// oam_dma_ctrl_pkg
//   Shared constants and types for the CPU memory-bus / OAM DMA controller.
//   - OAM_DMA_REG : CPU write address that starts a sprite DMA
//   - OAM_DATA    : destination address of every DMA write
//   - dma_state_e : controller FSM states (codes fixed by the ST_* constants)
//   - xfer_last_idx() : last idx value for a given transfer length
package oam_dma_ctrl_pkg;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_DATA    = 16'h2004;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HALT     = 3'd1;
    localparam logic [2:0] ST_ALIGN    = 3'd2;
    localparam logic [2:0] ST_READ     = 3'd3;
    localparam logic [2:0] ST_WRITE    = 3'd4;
    localparam logic [2:0] ST_DMC_READ = 3'd5;
    localparam logic [2:0] ST_DMC_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        HALT     = ST_HALT,
        ALIGN    = ST_ALIGN,
        READ     = ST_READ,
        WRITE    = ST_WRITE,
        DMC_READ = ST_DMC_READ,
        DMC_DONE = ST_DMC_DONE
    } dma_state_e;

    function automatic logic [7:0] xfer_last_idx(input int len);
        return 8'(len - 1);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
//   CPU memory-bus controller. Passes CPU accesses straight to memory while idle;
//   a CPU write to DMA_REG_ADDR stalls the CPU and copies XFER_LEN bytes from
//   {page,idx} to OAM_DATA_ADDR, one read clk and one write clk per byte.
//
//   Build option: define DMC_DMA_EN to add DMC sample fetches, which take priority
//   over OAM DMA and may steal a read slot in the middle of a transfer. Without it
//   dmc_req/dmc_addr are ignored and dmc_ack/dmc_data are tied to 0.
//
//   State table:
//     state    | meaning
//     IDLE     | CPU passthrough, no stall
//     HALT     | first stalled clk, bus idle
//     ALIGN    | bus idle, pushes the next read onto a get (parity 0) clk
//     READ     | read {page,idx}
//     WRITE    | write the byte just read to OAM_DATA_ADDR
//     DMC_READ | read dmc_addr (DMC_DMA_EN only)
//     DMC_DONE | capture DMC byte (DMC_DMA_EN only)
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   cpu_addr/read/write/wdata     CPU request (already stall-gated)
//   cpu_stall                     CPU halt, high for the whole DMA
//   bus_addr/read/write/wdata     memory request
//   bus_rdata                     memory read data, valid the clk after bus_read
//   dma_busy                      state != IDLE
//   dmc_req, dmc_addr             DMC fetch request and address
//   dmc_ack, dmc_data             1-clk fetch acknowledge with the fetched byte
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] bus_addr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
);

    localparam logic [7:0] LAST_IDX = xfer_last_idx(XFER_LEN);

    dma_state_e state;
    dma_state_e state_nxt;
    dma_state_e read_entry;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic       trigger;
    logic       last_byte;

    assign trigger   = cpu_write && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx == LAST_IDX);

`ifdef DMC_DMA_EN
    logic       oam_active;
    logic       dmc_go;
    logic       dmc_ack_q;
    logic [7:0] dmc_data_q;

    // The requester holds dmc_req until it sees dmc_ack; ignoring the request
    // on the ack clk keeps one request from being fetched twice.
    assign dmc_go   = dmc_req && !dmc_ack_q;
    assign dmc_ack  = dmc_ack_q;
    assign dmc_data = dmc_data_q;

    // Every transition that would start an OAM read is redirected to a DMC
    // read when a fetch is pending; a standalone DMC fetch always goes there.
    always_comb begin
        read_entry = READ;
        if (dmc_go || !oam_active)
            read_entry = DMC_READ;
    end
`else
    assign dmc_ack  = 1'b0;
    assign dmc_data = 8'h00;

    always_comb begin
        read_entry = READ;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef DMC_DMA_EN
                if (dmc_go || trigger)
                    state_nxt = HALT;
`else
                if (trigger)
                    state_nxt = HALT;
`endif
            end
            HALT:  state_nxt = parity ? read_entry : ALIGN;
            ALIGN: state_nxt = read_entry;
            READ:  state_nxt = WRITE;
            WRITE: begin
                if (last_byte)
                    state_nxt = IDLE;
                else
                    state_nxt = read_entry;
            end
`ifdef DMC_DMA_EN
            DMC_READ: state_nxt = DMC_DONE;
            // A stolen slot ends on a put clk, so the retried OAM read already
            // lands on a get clk and no ALIGN is needed (steal costs 2 clk).
            DMC_DONE: begin
                if (!oam_active)
                    state_nxt = IDLE;
                else if (parity)
                    state_nxt = READ;
                else
                    state_nxt = ALIGN;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            data_q <= 8'h00;
`ifdef DMC_DMA_EN
            oam_active <= 1'b0;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'h00;
`endif
        end else begin
            parity <= ~parity;
            state  <= state_nxt;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page <= cpu_wdata;
                        idx  <= 8'h00;
                    end
`ifdef DMC_DMA_EN
                    // A DMC request arriving with the trigger write wins and
                    // that OAM request is dropped.
                    oam_active <= trigger && !dmc_go;
`endif
                end
                WRITE: begin
                    data_q <= bus_rdata;
                    if (!last_byte)
                        idx <= idx + 8'd1;
                end
`ifdef DMC_DMA_EN
                DMC_DONE: dmc_data_q <= bus_rdata;
`endif
                default: ;
            endcase
`ifdef DMC_DMA_EN
            dmc_ack_q <= (state == DMC_DONE);
`endif
        end
    end

    always_comb begin
        bus_addr  = 16'h0000;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_wdata = 8'h00;
        case (state)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_read  = cpu_read;
                bus_write = cpu_write;
                bus_wdata = cpu_wdata;
            end
            READ: begin
                bus_addr = {page, idx};
                bus_read = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_write = 1'b1;
                bus_wdata = bus_rdata;
            end
`ifdef DMC_DMA_EN
            DMC_READ: begin
                bus_addr = dmc_addr;
                bus_read = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign cpu_stall = (state != IDLE);
    assign dma_busy  = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl
//   Self-checking bench for oam_dma_ctrl: passthrough vector table, OAM DMA runs on
//   both trigger parities with a bus-event scoreboard, mid-transfer reset and, when
//   DMC_DMA_EN is defined, DMC fetches standalone and stolen from an OAM transfer.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_stall;
    logic [15:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        dma_busy;
    logic        dmc_req = 1'b0;
    logic [15:0] dmc_addr = 16'h0000;
    logic        dmc_ack;
    logic [7:0]  dmc_data;

    oam_dma_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .bus_addr  (bus_addr),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .dma_busy  (dma_busy),
        .dmc_req   (dmc_req),
        .dmc_addr  (dmc_addr),
        .dmc_ack   (dmc_ack),
        .dmc_data  (dmc_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_ev_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        logic [15:0] e_addr;
        logic        e_rd;
        logic        e_wr;
        logic [7:0]  e_wdata;
        logic        e_stall;
    } pt_vec_t;

    bus_ev_t    exp_q[$];
    pt_vec_t    vecs[6];
    logic [7:0] mem[0:65535];
    int         n_vec = 0;
    int         n_err = 0;
    int         stall_cnt = 0;
    int         ack_cnt = 0;
    int         x_err = 0;
    int         oam_wr_cnt = 0;
    logic [7:0] ack_data = 8'h00;
    logic       tb_par;

    // Parity reference: 0 on the first clk after reset, toggling every clk.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    // Memory model: read data returned the clk after bus_read.
    always @(posedge clk) begin
        if (bus_read) bus_rdata <= mem[bus_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every bus access made while busy must match the
    // next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_stall) stall_cnt++;
            if (dmc_ack) begin
                ack_cnt++;
                ack_data = dmc_data;
            end
            if (bus_write && bus_addr == 16'h2004) oam_wr_cnt++;
            if (dma_busy) begin
                if ($isunknown({cpu_stall, bus_addr, bus_read, bus_write, bus_wdata, dmc_ack, dmc_data}))
                    x_err++;
                if (bus_read || bus_write) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL bus op: got wr=%b addr=%h with no expected access", bus_write, bus_addr);
                    end else begin
                        bus_ev_t e;
                        e = exp_q.pop_front();
                        check("bus op", {bus_write, bus_read, bus_addr, bus_write ? bus_wdata : 8'h00},
                              {e.wr, !e.wr, e.addr, e.wr ? e.data : 8'h00});
                    end
                end
            end
        end
    end

    task automatic run_table();
        for (int v = 0; v < 6; v++) begin
            cpu_addr  = vecs[v].addr;
            cpu_read  = vecs[v].rd;
            cpu_write = vecs[v].wr;
            cpu_wdata = vecs[v].wdata;
            #1;
            check($sformatf("passthrough %0d", v), {bus_addr, bus_read, bus_write, bus_wdata, cpu_stall},
                  {vecs[v].e_addr, vecs[v].e_rd, vecs[v].e_wr, vecs[v].e_wdata, vecs[v].e_stall});
            @(negedge clk);
            check($sformatf("no trigger %0d", v), {dma_busy, cpu_stall}, 2'b00);
        end
        cpu_addr = 16'h0000; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = 8'h00;
    endtask

    // Drives the $4014 write on a clk of the requested parity and queues the
    // expected transfer; dmc_at >= 0 inserts a DMC read before that idx.
    task automatic trigger_oam(input logic [7:0] page, input logic par, input int dmc_at,
                               input logic [15:0] daddr);
        int g = 0;
        while (tb_par !== par && g < 4) begin
            @(negedge clk);
            g++;
        end
        cpu_addr = 16'h4014; cpu_write = 1'b1; cpu_wdata = page;
        for (int i = 0; i < 256; i++) begin
            if (i == dmc_at) exp_q.push_back('{1'b0, daddr, 8'h00});
            exp_q.push_back('{1'b0, {page, i[7:0]}, 8'h00});
            exp_q.push_back('{1'b1, 16'h2004, mem[{page, i[7:0]}]});
        end
        stall_cnt = 0; ack_cnt = 0; x_err = 0;
        #1;
        check("trigger on bus", {bus_write, bus_addr, bus_wdata, cpu_stall}, {1'b1, 16'h4014, page, 1'b0});
        @(negedge clk);
        cpu_addr = 16'h0000; cpu_write = 1'b0; cpu_wdata = 8'h00;
    endtask

    task automatic run_oam(input logic [7:0] page, input logic par, input int exp_stall,
                           input int dmc_at, input logic [15:0] daddr);
        int cyc = 0;
        trigger_oam(page, par, dmc_at, daddr);
        for (int k = 0; k < 2000; k++) begin
            if (!dma_busy) break;
            cyc++;
            // Raise the request during the WRITE of idx dmc_at-1 so it is
            // sampled as the read of idx dmc_at is about to start.
            if (dmc_at > 0 && cyc == 3 + int'(par) + 2 * (dmc_at - 1)) begin
                dmc_req = 1'b1;
                dmc_addr = daddr;
            end
            if (dmc_ack) dmc_req = 1'b0;
            @(negedge clk);
        end
        check("dma finished", {31'd0, dma_busy}, 32'd0);
        check("stall length", stall_cnt, exp_stall);
        check("events left", exp_q.size(), 0);
        check("x while busy", x_err, 0);
        check("idle bus", {bus_addr, bus_read, bus_write, bus_wdata, cpu_stall}, 27'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ 8'h5A;

        vecs[0] = '{16'hC000, 1'b1, 1'b0, 8'h00, 16'hC000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{16'h0010, 1'b0, 1'b1, 8'h33, 16'h0010, 1'b0, 1'b1, 8'h33, 1'b0};
        vecs[2] = '{16'h4014, 1'b1, 1'b0, 8'h00, 16'h4014, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{16'h4013, 1'b0, 1'b1, 8'h02, 16'h4013, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[4] = '{16'h2004, 1'b0, 1'b1, 8'h77, 16'h2004, 1'b0, 1'b1, 8'h77, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b0, 1'b0, 8'hA5, 16'hFFFF, 1'b0, 1'b0, 8'hA5, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("reset stall/busy", {cpu_stall, dma_busy, dmc_ack}, 3'b000);
        check("reset dmc_data", dmc_data, 8'h00);
        check("reset bus", {bus_addr, bus_read, bus_write, bus_wdata}, 26'd0);
        @(negedge clk);
        rst = 1'b0;

        run_table();

        // Trigger clk parity 1: HALT falls on parity 0, so ALIGN is inserted.
        run_oam(8'h02, 1'b1, 514, -1, 16'h0000);
        // Trigger clk parity 0: HALT on parity 1, straight to READ.
        run_oam(8'h07, 1'b0, 513, -1, 16'h0000);
        run_oam(8'hA5, 1'b1, 514, -1, 16'h0000);

        // Reset in the middle of a transfer.
        trigger_oam(8'h02, 1'b0, -1, 16'h0000);
        for (int k = 0; k < 1000; k++) begin
            if (bus_read && bus_addr == 16'h0280) break;
            @(negedge clk);
        end
        check("reached idx 80", {bus_read, bus_addr}, {1'b1, 16'h0280});
        rst = 1'b1;
        #1;
        check("mid reset stall/busy", {cpu_stall, dma_busy, dmc_ack}, 3'b000);
        check("mid reset dmc_data", dmc_data, 8'h00);
        check("mid reset bus", {bus_addr, bus_read, bus_write, bus_wdata}, 26'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        oam_wr_cnt = 0;
        repeat (600) @(negedge clk);
        check("no oam writes after reset", oam_wr_cnt, 0);
        check("idle after reset", {31'd0, dma_busy}, 32'd0);
        run_table();

`ifdef DMC_DMA_EN
        // DMC fetch steals the slot of idx 8'h10; that idx is then read.
        run_oam(8'h03, 1'b0, 515, 16, 16'hC100);
        check("steal ack count", ack_cnt, 1);
        check("steal ack data", ack_data, mem[16'hC100]);

        // Standalone DMC fetch from IDLE on a parity-0 clk: HALT, DMC_READ, DMC_DONE.
        while (tb_par !== 1'b0) @(negedge clk);
        dmc_addr = 16'hC123;
        dmc_req = 1'b1;
        exp_q.push_back('{1'b0, 16'hC123, 8'h00});
        stall_cnt = 0; ack_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dmc_ack) begin
                dmc_req = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
        check("dmc stall length", stall_cnt, 3);
        check("dmc ack count", ack_cnt, 1);
        check("dmc ack data", ack_data, mem[16'hC123]);
        check("dmc data held", dmc_data, mem[16'hC123]);
        check("dmc events left", exp_q.size(), 0);
        check("dmc idle", {31'd0, dma_busy}, 32'd0);
`else
        check("no dmc ack", ack_cnt, 0);
        check("dmc data zero", dmc_data, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
